branch_cmp_arbiter: RTL and testbench

BRANCH_CMP_ARBITER -- requirements
Module: branch_cmp_arbiter

---
 rtl/branch_cmp_arbiter.sv | 104 ++++++++++
 tb/tb_branch_cmp_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_arbiter.sv
// Two-requester branch comparator with a single registered response slot.
// Round-robin arbitration on ties; counts accepted compares and taken results.
module branch_cmp_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_funct3,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_rs2,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_funct3,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_rs2,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_taken,
    output logic             rsp_err,

    output logic [CNT_W-1:0] cmp_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            state;
    logic            last_grant;
    logic            slot_open;
    logic            gnt0;
    logic            gnt1;
    logic            grant;
    logic [2:0]      sel_funct3;
    logic [XLEN-1:0] sel_rs1;
    logic [XLEN-1:0] sel_rs2;
    logic            dec_taken;
    logic            dec_err;

    // Readies are forced low while reset is asserted so no handshake can complete.
    assign slot_open = !reset && ((state == ST_EMPTY) || rsp_ready);

    assign gnt0  = slot_open && req0_valid && (!req1_valid || last_grant);
    assign gnt1  = slot_open && req1_valid && (!req0_valid || !last_grant);
    assign grant = gnt0 || gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state == ST_FULL);

    assign sel_funct3 = gnt1 ? req1_funct3 : req0_funct3;
    assign sel_rs1    = gnt1 ? req1_rs1    : req0_rs1;
    assign sel_rs2    = gnt1 ? req1_rs2    : req0_rs2;

    always_comb begin
        dec_taken = 1'b0;
        dec_err   = 1'b0;
        case (sel_funct3)
            3'b000:  dec_taken = (sel_rs1 == sel_rs2);
            3'b001:  dec_taken = (sel_rs1 != sel_rs2);
            3'b100:  dec_taken = ($signed(sel_rs1) <  $signed(sel_rs2));
            3'b101:  dec_taken = !($signed(sel_rs1) < $signed(sel_rs2));
            3'b110:  dec_taken = (sel_rs1 <  sel_rs2);
            3'b111:  dec_taken = !(sel_rs1 < sel_rs2);
            default: dec_err   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_EMPTY;
            last_grant  <= 1'b1;
            rsp_id      <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_err     <= 1'b0;
            cmp_count   <= '0;
            taken_count <= '0;
        end else begin
            if (grant) begin
                state      <= ST_FULL;
                last_grant <= gnt1;
                rsp_id     <= gnt1;
                rsp_taken  <= dec_taken;
                rsp_err    <= dec_err;
                cmp_count  <= cmp_count + CNT_ONE;
                if (dec_taken) begin
                    taken_count <= taken_count + CNT_ONE;
                end
            end else if ((state == ST_FULL) && rsp_ready) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Directed bench for branch_cmp_arbiter; a second instance with narrow
// counters exercises counter wrap-around.
module tb_branch_cmp_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_funct3, req1_funct3;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_taken, rsp_err;
    logic [15:0] cmp_count, taken_count;

    logic        w_reset;
    logic        w_req0_valid, w_req1_valid;
    logic        w_req0_ready, w_req1_ready;
    logic [2:0]  w_req0_funct3, w_req1_funct3;
    logic [31:0] w_req0_rs1, w_req0_rs2, w_req1_rs1, w_req1_rs2;
    logic        w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_taken, w_rsp_err;
    logic [3:0]  w_cmp_count, w_taken_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_cmp_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_taken(rsp_taken), .rsp_err(rsp_err),
        .cmp_count(cmp_count), .taken_count(taken_count)
    );

    branch_cmp_arbiter #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(w_reset),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_funct3(w_req0_funct3),
        .req0_rs1(w_req0_rs1), .req0_rs2(w_req0_rs2),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_funct3(w_req1_funct3),
        .req1_rs1(w_req1_rs1), .req1_rs2(w_req1_rs2),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id),
        .rsp_taken(w_rsp_taken), .rsp_err(w_rsp_err),
        .cmp_count(w_cmp_count), .taken_count(w_taken_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;  w_reset = 1'b1;
        req0_valid = 1'b1; req0_funct3 = 3'b000; req0_rs1 = 32'd5; req0_rs2 = 32'd5;
        req1_valid = 1'b1; req1_funct3 = 3'b001; req1_rs1 = 32'd1; req1_rs2 = 32'd2;
        rsp_ready = 1'b1;
        w_req0_valid = 1'b0; w_req0_funct3 = 3'b000; w_req0_rs1 = 32'd9; w_req0_rs2 = 32'd9;
        w_req1_valid = 1'b0; w_req1_funct3 = 3'b000; w_req1_rs1 = '0; w_req1_rs2 = '0;
        w_rsp_ready = 1'b1;

        // Held in reset with both requesters valid
        tick(); tick();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cmp_count", cmp_count, 0);
        check("rst_taken_count", taken_count, 0);
        check("rst_rsp_id", rsp_id, 0);
        reset = 1'b0; w_reset = 1'b0;
        #1;

        // Round-robin under a permanent tie with rsp_ready held high
        for (int i = 0; i < 4; i++) begin
            check("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_rsp_valid", rsp_valid, 1);
            check("rr_rsp_id", rsp_id, (i % 2 == 1) ? 1 : 0);
            check("rr_taken", rsp_taken, 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("rr_drain_valid", rsp_valid, 0);
        check("rr_cmp_count", cmp_count, 4);
        check("rr_taken_count", taken_count, 4);

        // Signed vs unsigned compare on 0xFFFFFFFF vs 1
        req0_valid = 1'b1; req0_rs1 = 32'hFFFF_FFFF; req0_rs2 = 32'd1;
        req0_funct3 = 3'b100;
        tick();
        check("blt_taken", rsp_taken, 1);
        check("blt_err", rsp_err, 0);
        req0_funct3 = 3'b110;
        tick();
        check("bltu_taken", rsp_taken, 0);
        req0_funct3 = 3'b111;
        tick();
        check("bgeu_taken", rsp_taken, 1);
        req0_funct3 = 3'b101;
        tick();
        check("bge_taken", rsp_taken, 0);
        req0_valid = 1'b0;
        tick();
        check("sgn_drain_valid", rsp_valid, 0);
        check("sgn_cmp_count", cmp_count, 8);
        check("sgn_taken_count", taken_count, 6);

        // Backpressure: held result stays stable, req1 waits
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_funct3 = 3'b000; req0_rs1 = 32'd3; req0_rs2 = 32'd4;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_funct3 = 3'b110; req1_rs1 = 32'd1; req1_rs2 = 32'd2;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready1", req1_ready, 0);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 0);
            check("bp_rsp_taken", rsp_taken, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready1", req1_ready, 1);
        tick();
        check("bp_new_id", rsp_id, 1);
        check("bp_new_taken", rsp_taken, 1);
        req1_valid = 1'b0;
        tick();
        check("bp_drain_valid", rsp_valid, 0);
        check("bp_cmp_count", cmp_count, 10);
        check("bp_taken_count", taken_count, 7);

        // Legal then illegal funct3 from a fresh reset
        reset = 1'b1; #2; reset = 1'b0;
        req0_valid = 1'b1; req0_funct3 = 3'b000; req0_rs1 = 32'd7; req0_rs2 = 32'd7;
        tick();
        check("beq_taken", rsp_taken, 1);
        check("beq_err", rsp_err, 0);
        req0_funct3 = 3'b010;
        tick();
        check("ill_taken", rsp_taken, 0);
        check("ill_err", rsp_err, 1);
        req0_valid = 1'b0;
        tick();
        check("ill_cmp_count", cmp_count, 2);
        check("ill_taken_count", taken_count, 1);

        // Asynchronous reset while FULL, then tie must go to req0
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_funct3 = 3'b011;
        tick();
        check("pre_rst_full", rsp_valid, 1);
        check("pre_rst_err", rsp_err, 1);
        req0_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_valid", rsp_valid, 0);
        check("async_rst_cmp", cmp_count, 0);
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_funct3 = 3'b000;
        #1;
        check("post_rst_ready0", req0_ready, 1);
        check("post_rst_ready1", req1_ready, 0);
        tick();
        check("post_rst_id", rsp_id, 0);
        check("post_rst_cmp", cmp_count, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Narrow counters wrap after 17 taken grants
        w_req0_valid = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        w_req0_valid = 1'b0;
        tick();
        check("wrap_cmp_count", w_cmp_count, 1);
        check("wrap_taken_count", w_taken_count, 1);
        check("wrap_drain_valid", w_rsp_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
